// File: rtl/gcc_pkg.sv
// Shared types and constants for the GCC-PHAT delay path.
// Delay vectors are packed signed lags, one per microphone pair.
package gcc_pkg;
    localparam int DELAY_LANES    = 3;
    localparam int DELAY_W        = 16;
    localparam int AVG_LOG2_DEPTH = 3;

    typedef logic signed [DELAY_W-1:0] delay_t;
    typedef delay_t [DELAY_LANES-1:0] delay_vec_t;

    // Sign-extend one lag into the running-sum width.
    function automatic logic signed [DELAY_W+AVG_LOG2_DEPTH-1:0] widen_lag(input delay_t x);
        return {{AVG_LOG2_DEPTH{x[DELAY_W-1]}}, x};
    endfunction
endpackage

// File: rtl/tdoa_avg_lane.sv
// One averaging lane: ring slice, running window sum and the floor-divide shift.
// The top supplies clear-adjusted pointer and fullness so this lane stays stateless about the window.
module tdoa_avg_lane
    import gcc_pkg::*;
#(
    parameter int LANE_W     = DELAY_W,
    parameter int LOG2_DEPTH = AVG_LOG2_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     accept_i,
    input  logic                     full_i,
    input  logic [LOG2_DEPTH-1:0]    wr_ptr_i,
    input  logic signed [LANE_W-1:0] x_i,
    output logic signed [LANE_W-1:0] avg_o
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = LANE_W + LOG2_DEPTH;

    logic signed [LANE_W-1:0] ring_q [DEPTH];
    logic signed [SUM_W-1:0]  sum_q;
    logic signed [SUM_W-1:0]  sum_d;
    logic signed [SUM_W-1:0]  x_ext_s;
    logic signed [SUM_W-1:0]  old_ext_s;
    logic signed [SUM_W-1:0]  base_s;

    // Next running sum; the oldest sample only leaves once the window is full.
    always_comb begin
        x_ext_s   = {{LOG2_DEPTH{x_i[LANE_W-1]}}, x_i};
        old_ext_s = '0;
        if (full_i) begin
            old_ext_s = {{LOG2_DEPTH{ring_q[wr_ptr_i][LANE_W-1]}}, ring_q[wr_ptr_i]};
        end else begin
            old_ext_s = '0;
        end
        base_s = clear_i ? '0 : sum_q;
        if (accept_i) begin
            sum_d = base_s + x_ext_s - old_ext_s;
        end else begin
            sum_d = base_s;
        end
        avg_o = LANE_W'(sum_d >>> LOG2_DEPTH);
    end

    // Running sum register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    // Sample history; contents are irrelevant until rewritten, so no reset.
    always_ff @(posedge clk) begin
        if (accept_i) begin
            ring_q[wr_ptr_i] <= x_i;
        end
    end
endmodule

// File: rtl/tdoa_delay_avg.sv
// Per-lane moving average of GCC-PHAT TDOA lags over the last 2**LOG2_DEPTH frames.
// AXI-Stream in/out with a single output register; raw passthrough until the window is full.
module tdoa_delay_avg
    import gcc_pkg::*;
#(
    parameter int NUM_LANES  = DELAY_LANES,
    parameter int LANE_W     = DELAY_W,
    parameter int LOG2_DEPTH = AVG_LOG2_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic [NUM_LANES*LANE_W-1:0]   S_AXIS_DELAYS_tdata,
    input  logic                          S_AXIS_DELAYS_tvalid,
    output logic                          S_AXIS_DELAYS_tready,
    output logic [NUM_LANES*LANE_W-1:0]   M_AXIS_AVG_tdata,
    output logic                          M_AXIS_AVG_tuser,
    output logic                          M_AXIS_AVG_tvalid,
    input  logic                          M_AXIS_AVG_tready
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int CNT_W = LOG2_DEPTH + 1;

    logic [LOG2_DEPTH-1:0]         wr_ptr_q, wr_ptr_d, ptr_eff_s;
    logic [CNT_W-1:0]              fill_q, fill_d, fill_eff_s;
    logic                          accept_s, full_s, steady_s;
    logic                          m_valid_q;
    logic                          m_user_q;
    logic [NUM_LANES*LANE_W-1:0]   m_data_q, m_data_d;

    assign S_AXIS_DELAYS_tready = !m_valid_q || M_AXIS_AVG_tready;
    assign accept_s             = S_AXIS_DELAYS_tvalid && S_AXIS_DELAYS_tready;
    assign M_AXIS_AVG_tvalid    = m_valid_q;
    assign M_AXIS_AVG_tdata     = m_data_q;
    assign M_AXIS_AVG_tuser     = m_user_q;

    // Window bookkeeping; a clear in the same cycle makes this beat the first of a new window.
    always_comb begin
        ptr_eff_s  = clear ? '0 : wr_ptr_q;
        fill_eff_s = clear ? '0 : fill_q;
        full_s     = (fill_eff_s == CNT_W'(DEPTH));
        wr_ptr_d   = ptr_eff_s;
        fill_d     = fill_eff_s;
        if (accept_s) begin
            wr_ptr_d = ptr_eff_s + LOG2_DEPTH'(1);
            if (!full_s) begin
                fill_d = fill_eff_s + CNT_W'(1);
            end else begin
                fill_d = fill_eff_s;
            end
        end else begin
            wr_ptr_d = ptr_eff_s;
        end
        steady_s = (fill_d == CNT_W'(DEPTH));
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic signed [LANE_W-1:0] x_s;
        logic signed [LANE_W-1:0] avg_s;

        assign x_s = S_AXIS_DELAYS_tdata[g*LANE_W +: LANE_W];

        tdoa_avg_lane #(
            .LANE_W     (LANE_W),
            .LOG2_DEPTH (LOG2_DEPTH)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clear_i  (clear),
            .accept_i (accept_s),
            .full_i   (full_s),
            .wr_ptr_i (ptr_eff_s),
            .x_i      (x_s),
            .avg_o    (avg_s)
        );

        assign m_data_d[g*LANE_W +: LANE_W] = steady_s ? avg_s : x_s;
    end

    // Window pointer and fill counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Output register: load on accept, drop on drain, otherwise hold stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_user_q  <= 1'b0;
        end else if (accept_s) begin
            m_valid_q <= 1'b1;
            m_data_q  <= m_data_d;
            m_user_q  <= steady_s;
        end else if (M_AXIS_AVG_tready) begin
            m_valid_q <= 1'b0;
        end else begin
            m_valid_q <= m_valid_q;
        end
    end
endmodule

// File: tb/tb_tdoa_delay_avg.sv
// Self-checking bench for tdoa_delay_avg: a window model feeds a scoreboard of expected beats,
// and scenario tasks add inline checks on reset, warm-up, floor, extremes, backpressure and clear.
module tb_tdoa_delay_avg;
    localparam int NL    = 3;
    localparam int W     = 16;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst, clear, s_valid, s_ready, m_valid, m_ready, m_user;
    logic [NL*W-1:0] s_data, m_data;

    int tests_run = 0, tests_failed = 0;
    int mon_run = 0, mon_failed = 0;

    logic [NL*W:0]   exp_q[$];
    logic [NL*W-1:0] win_q[$];
    logic [NL*W:0]   mon_e;
    logic [NL*W-1:0] mon_avg;
    logic signed [W-1:0] mon_v;
    int mon_s, mon_r, mon_f;

    always #5 clk = ~clk;

    tdoa_delay_avg dut (
        .clk                  (clk),
        .rst                  (rst),
        .clear                (clear),
        .S_AXIS_DELAYS_tdata  (s_data),
        .S_AXIS_DELAYS_tvalid (s_valid),
        .S_AXIS_DELAYS_tready (s_ready),
        .M_AXIS_AVG_tdata     (m_data),
        .M_AXIS_AVG_tuser     (m_user),
        .M_AXIS_AVG_tvalid    (m_valid),
        .M_AXIS_AVG_tready    (m_ready)
    );

    function automatic logic [NL*W-1:0] pk(input int a, input int b, input int c);
        return {c[15:0], b[15:0], a[15:0]};
    endfunction

    // Monitor: retire output transfers against the scoreboard, then model accepted inputs.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            win_q.delete();
        end else begin
            if (m_valid && m_ready) begin
                mon_run++;
                if (exp_q.size() == 0) begin
                    mon_failed++;
                    $display("FAIL sb_extra: got user=%0b data=%h, expected no beat", m_user, m_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({m_user, m_data} !== mon_e) begin
                        mon_failed++;
                        $display("FAIL sb_beat: got user=%0b data=%h, expected user=%0b data=%h",
                                 m_user, m_data, mon_e[NL*W], mon_e[NL*W-1:0]);
                    end
                end
            end
            if (clear) win_q.delete();
            if (s_valid && s_ready) begin
                win_q.push_back(s_data);
                if (win_q.size() > DEPTH) void'(win_q.pop_front());
                if (win_q.size() == DEPTH) begin
                    for (int l = 0; l < NL; l++) begin
                        mon_s = 0;
                        for (int k = 0; k < DEPTH; k++) begin
                            mon_v = win_q[k][l*W +: W];
                            mon_s += int'(mon_v);
                        end
                        mon_r = mon_s % DEPTH;
                        mon_f = (mon_s - ((mon_r + DEPTH) % DEPTH)) / DEPTH;
                        mon_avg[l*W +: W] = mon_f[15:0];
                    end
                    exp_q.push_back({1'b1, mon_avg});
                end else begin
                    exp_q.push_back({1'b0, s_data});
                end
            end
        end
    end

    task automatic send(input logic [NL*W-1:0] d, input logic clr);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        clear   = clr;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: tready=%0b after %0d cycles, expected 1", s_ready, n);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        clear   = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0 || m_valid) begin
            tests_failed++;
            $display("FAIL drain: pending=%0d tvalid=%0b, expected 0 and 0", exp_q.size(), m_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run++;
        if ({m_valid, m_user, m_data, s_ready} !== {1'b0, 1'b0, 48'h0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_state: got valid=%0b user=%0b data=%h ready=%0b, expected 0 0 0 1",
                     m_valid, m_user, m_data, s_ready);
        end
    endtask

    task automatic test_warmup();
        for (int i = 0; i < 7; i++) begin
            send(pk(1, 2, 3), 1'b0);
            tests_run++;
            if ({m_valid, m_user, m_data} !== {1'b1, 1'b0, pk(1, 2, 3)}) begin
                tests_failed++;
                $display("FAIL warmup_echo: got valid=%0b user=%0b data=%h, expected 1 0 %h",
                         m_valid, m_user, m_data, pk(1, 2, 3));
            end
        end
    endtask

    task automatic test_constant();
        do_clear();
        for (int i = 0; i < 11; i++) begin
            send(pk(5, -3, 100), 1'b0);
            if (i >= 7) begin
                tests_run++;
                if ({m_user, m_data} !== {1'b1, pk(5, -3, 100)}) begin
                    tests_failed++;
                    $display("FAIL constant: got user=%0b data=%h, expected 1 %h",
                             m_user, m_data, pk(5, -3, 100));
                end
            end
        end
    endtask

    task automatic test_step();
        do_clear();
        for (int i = 0; i < 8; i++) send(pk(0, 0, 0), 1'b0);
        for (int i = 0; i < 8; i++) begin
            send(pk(16, 0, 0), 1'b0);
            tests_run++;
            if (m_data[15:0] !== 16'(2 * (i + 1))) begin
                tests_failed++;
                $display("FAIL step: got lane0=%0d, expected %0d", $signed(m_data[15:0]), 2 * (i + 1));
            end
        end
    endtask

    task automatic test_floor();
        do_clear();
        send(pk(-1, 0, 0), 1'b0);
        for (int i = 0; i < 7; i++) send(pk(0, 0, 0), 1'b0);
        tests_run++;
        if ({m_user, m_data} !== {1'b1, 32'h0, 16'hFFFF}) begin
            tests_failed++;
            $display("FAIL floor: got user=%0b data=%h, expected 1 %h", m_user, m_data, {32'h0, 16'hFFFF});
        end
    endtask

    task automatic test_extremes();
        do_clear();
        for (int i = 0; i < 8; i++) send(pk(32767, 32767, 32767), 1'b0);
        tests_run++;
        if (m_data !== {3{16'h7FFF}}) begin
            tests_failed++;
            $display("FAIL max: got %h, expected %h", m_data, {3{16'h7FFF}});
        end
        for (int i = 0; i < 8; i++) send(pk(-32768, -32768, -32768), 1'b0);
        tests_run++;
        if (m_data !== {3{16'h8000}}) begin
            tests_failed++;
            $display("FAIL min: got %h, expected %h", m_data, {3{16'h8000}});
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [NL*W-1:0] a;
        a = pk(11, 22, 33);
        do_clear();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = a;
        @(posedge clk);
        #1;
        s_data = pk(44, 55, 66);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if ({s_ready, m_valid, m_data} !== {1'b0, 1'b1, a}) begin
                tests_failed++;
                $display("FAIL bp_hold: got ready=%0b valid=%0b data=%h, expected 0 1 %h",
                         s_ready, m_valid, m_data, a);
            end
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        send(pk(44, 55, 66), 1'b0);
        for (int i = 0; i < 10; i++) begin
            send(pk(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 65535))), 1'b0);
        end
        drain();
    endtask

    task automatic test_clear_mid();
        do_clear();
        for (int i = 0; i < 5; i++) send(pk(10, 20, 30), 1'b0);
        send(pk(7, 7, 7), 1'b1);
        tests_run++;
        if (m_user !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_accept: got user=%0b, expected 0", m_user);
        end
        for (int i = 0; i < 7; i++) begin
            send(pk(8 * i, -i, 3), 1'b0);
            tests_run++;
            if (m_user !== (i == 6)) begin
                tests_failed++;
                $display("FAIL clear_window: beat %0d got user=%0b, expected %0b", i, m_user, (i == 6));
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        send(pk(9, 9, 9), 1'b0);
        tests_run++;
        if (m_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pending: got valid=%0b, expected 1", m_valid);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run++;
        if ({m_valid, m_data} !== {1'b0, 48'h0}) begin
            tests_failed++;
            $display("FAIL rst_drop: got valid=%0b data=%h, expected 0 0", m_valid, m_data);
        end
        m_ready = 1'b1;
        send(pk(4, 5, 6), 1'b0);
        tests_run++;
        if ({m_user, m_data} !== {1'b0, pk(4, 5, 6)}) begin
            tests_failed++;
            $display("FAIL rst_restart: got user=%0b data=%h, expected 0 %h", m_user, m_data, pk(4, 5, 6));
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_constant();
        test_step();
        test_floor();
        test_extremes();
        test_backpressure();
        test_clear_mid();
        test_reset_mid();
        @(posedge clk);
        #1;
        tests_run    += mon_run;
        tests_failed += mon_failed;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
